alu_exec_ctrl: RTL and testbench

ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

---
 rtl/alu_exec_pkg.sv | 33 +++
 rtl/alu_exec_decode.sv | 43 ++++
 rtl/alu_exec_ctrl.sv | 110 +++++++++++
 tb/tb_alu_exec_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared constants for the ALU execute controller: ALU control codes, opcode/funct
// encodings and the FSM state type.
package alu_exec_pkg;

   localparam logic [3:0] ALU_AND     = 4'd0;
   localparam logic [3:0] ALU_OR      = 4'd1;
   localparam logic [3:0] ALU_ADD     = 4'd2;
   localparam logic [3:0] ALU_SUB     = 4'd6;
   localparam logic [3:0] ALU_SLT     = 4'd7;
   localparam logic [3:0] ALU_NOR     = 4'd12;
   localparam logic [3:0] ALU_ILLEGAL = 4'd15;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_exec_decode.sv
// Combinational decode of (opcode, funct) into ALU control plus branch/illegal/overflow
// qualifiers.
module alu_exec_decode
   import alu_exec_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [3:0] alu_ctl,
   output logic       is_beq,
   output logic       is_bne,
   output logic       illegal,
   output logic       ovf_check
);

   always_comb begin
      alu_ctl   = ALU_ILLEGAL;
      is_beq    = 1'b0;
      is_bne    = 1'b0;
      illegal   = 1'b1;
      ovf_check = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            illegal = 1'b0;
            case (funct)
               FN_ADD:  begin alu_ctl = ALU_ADD; ovf_check = 1'b1; end
               FN_SUB:  begin alu_ctl = ALU_SUB; ovf_check = 1'b1; end
               FN_AND:  alu_ctl = ALU_AND;
               FN_OR:   alu_ctl = ALU_OR;
               FN_NOR:  alu_ctl = ALU_NOR;
               FN_SLT:  alu_ctl = ALU_SLT;
               default: illegal = 1'b1;
            endcase
         end
         OP_ADDI: begin alu_ctl = ALU_ADD; illegal = 1'b0; ovf_check = 1'b1; end
         // Address arithmetic for loads/stores never reports overflow.
         OP_LW, OP_SW: begin alu_ctl = ALU_ADD; illegal = 1'b0; end
         OP_BEQ: begin alu_ctl = ALU_SUB; illegal = 1'b0; is_beq = 1'b1; end
         OP_BNE: begin alu_ctl = ALU_SUB; illegal = 1'b0; is_bne = 1'b1; end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Three-state (IDLE/EXEC/DONE) controller that drives an external ALU from registered
// operands and latches its result. Optional overflow detection: ALU_EXEC_OVF_DETECT_EN.
module alu_exec_ctrl
   import alu_exec_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [5:0]  in_opcode,
   input  logic [5:0]  in_funct,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic [3:0]  alu_ctl,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [31:0] alu_out,
   input  logic        alu_zero,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_taken,
   output logic        out_illegal,
   output logic        out_ovf
);

   state_t     state;
   logic [3:0] dec_ctl;
   logic       dec_beq, dec_bne, dec_illegal, dec_ovf_check;
   logic       is_beq, is_bne, illegal, ovf_chk;

   alu_exec_decode u_decode (
      .opcode    (in_opcode),
      .funct     (in_funct),
      .alu_ctl   (dec_ctl),
      .is_beq    (dec_beq),
      .is_bne    (dec_bne),
      .illegal   (dec_illegal),
      .ovf_check (dec_ovf_check)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         alu_ctl     <= ALU_AND;
         alu_a       <= '0;
         alu_b       <= '0;
         is_beq      <= 1'b0;
         is_bne      <= 1'b0;
         illegal     <= 1'b0;
         ovf_chk     <= 1'b0;
         out_result  <= '0;
         out_taken   <= 1'b0;
         out_illegal <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (in_valid) begin
               alu_a    <= in_a;
               alu_b    <= in_b;
               alu_ctl  <= dec_ctl;
               is_beq   <= dec_beq;
               is_bne   <= dec_bne;
               illegal  <= dec_illegal;
               ovf_chk  <= dec_ovf_check;
               in_ready <= 1'b0;
               state    <= ST_EXEC;
            end
            ST_EXEC: begin
               // Illegal requests discard whatever the ALU produced.
               out_result  <= illegal ? '0 : alu_out;
               out_taken   <= (is_beq & alu_zero) | (is_bne & ~alu_zero);
               out_illegal <= illegal;
               out_valid   <= 1'b1;
               state       <= ST_DONE;
            end
            ST_DONE: if (out_ready) begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= ST_IDLE;
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef ALU_EXEC_OVF_DETECT_EN
   logic ovf_add, ovf_sub, ovf_q;
   assign ovf_add = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
   assign ovf_sub = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);

   always_ff @(posedge clock) begin
      if (reset)
         ovf_q <= 1'b0;
      else if (state == ST_EXEC)
         ovf_q <= ovf_chk & ~illegal & ((alu_ctl == ALU_SUB) ? ovf_sub : ovf_add);
   end
   assign out_ovf = ovf_q;
`else
   logic unused_ovf_chk;
   assign unused_ovf_chk = ovf_chk;
   assign out_ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed plus randomized bench for alu_exec_ctrl with an instruction-level reference model.
module tb_alu_exec_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [5:0]  in_opcode = '0;
   logic [5:0]  in_funct = '0;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic [3:0]  alu_ctl;
   logic [31:0] alu_a, alu_b, alu_out;
   logic        alu_zero;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic        out_taken, out_illegal, out_ovf;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   alu_exec_ctrl dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_funct(in_funct), .in_a(in_a), .in_b(in_b),
      .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out(alu_out), .alu_zero(alu_zero),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_taken(out_taken),
      .out_illegal(out_illegal), .out_ovf(out_ovf)
   );

   always #5 clock = ~clock;

   // Environment ALU; an unknown control code yields a garbage pattern.
   always_comb begin
      alu_out = 32'hDEADBEEF;
      case (alu_ctl)
         4'd0:  alu_out = alu_a & alu_b;
         4'd1:  alu_out = alu_a | alu_b;
         4'd2:  alu_out = alu_a + alu_b;
         4'd6:  alu_out = alu_a - alu_b;
         4'd7:  alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
         4'd12: alu_out = ~(alu_a | alu_b);
         default: ;
      endcase
   end
   assign alu_zero = (alu_out == 32'd0);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit out_of_range(input longint s);
      return (s > 64'sd2147483647) || (s < -64'sd2147483648);
   endfunction

   // Instruction-level expectations from the decode rules and plain signed arithmetic.
   task automatic ref_model(input logic [5:0] op, input logic [5:0] fn,
                            input logic [31:0] a, input logic [31:0] b,
                            output logic [3:0] ctl, output logic [31:0] res,
                            output logic tk, output logic il, output logic ov);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ctl = 4'd15; res = '0; tk = 1'b0; il = 1'b1; ov = 1'b0;
      if (op == 6'h00) begin
         il = 1'b0;
         case (fn)
            6'h20: begin ctl = 4'd2;  res = a + b; ov = out_of_range(sa + sb); end
            6'h22: begin ctl = 4'd6;  res = a - b; ov = out_of_range(sa - sb); end
            6'h24: begin ctl = 4'd0;  res = a & b; end
            6'h25: begin ctl = 4'd1;  res = a | b; end
            6'h27: begin ctl = 4'd12; res = ~(a | b); end
            6'h2A: begin ctl = 4'd7;  res = (sa < sb) ? 32'd1 : 32'd0; end
            default: il = 1'b1;
         endcase
      end else if (op == 6'h08) begin
         ctl = 4'd2; res = a + b; il = 1'b0; ov = out_of_range(sa + sb);
      end else if (op == 6'h23 || op == 6'h2B) begin
         ctl = 4'd2; res = a + b; il = 1'b0;
      end else if (op == 6'h04 || op == 6'h05) begin
         ctl = 4'd6; res = a - b; il = 1'b0;
         tk = (op == 6'h04) ? (a == b) : (a != b);
      end
`ifndef ALU_EXEC_OVF_DETECT_EN
      ov = 1'b0;
`endif
   endtask

   task automatic run_req(input logic [5:0] op, input logic [5:0] fn,
                          input logic [31:0] a, input logic [31:0] b,
                          input int stall, input bit noise);
      logic [3:0]  ectl;
      logic [31:0] eres;
      logic        etk, eil, eov;
      ref_model(op, fn, a, b, ectl, eres, etk, eil, eov);
      check("idle_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_opcode = op; in_funct = fn; in_a = a; in_b = b; out_ready = 1'b0;
      @(posedge clock); #1;
      if (noise) begin
         in_opcode = 6'($urandom); in_funct = 6'($urandom); in_a = $urandom; in_b = $urandom;
      end else
         in_valid = 1'b0;
      check("exec_out_valid", 32'(out_valid), 32'd0);
      check("exec_in_ready", 32'(in_ready), 32'd0);
      check("exec_alu_ctl", 32'(alu_ctl), 32'(ectl));
      check("exec_alu_a", alu_a, a);
      check("exec_alu_b", alu_b, b);
      @(posedge clock); #1;
      for (int i = 0; i <= stall; i++) begin
         if (i > 0) begin @(posedge clock); #1; end
         check("done_out_valid", 32'(out_valid), 32'd1);
         check("done_in_ready", 32'(in_ready), 32'd0);
         check("done_result", out_result, eres);
         check("done_taken", 32'(out_taken), 32'(etk));
         check("done_illegal", 32'(out_illegal), 32'(eil));
         check("done_ovf", 32'(out_ovf), 32'(eov));
      end
      out_ready = 1'b1; in_valid = 1'b0;
      @(posedge clock); #1;
      out_ready = 1'b0;
      check("hs_out_valid", 32'(out_valid), 32'd0);
      check("hs_in_ready", 32'(in_ready), 32'd1);
   endtask

   task automatic reset_midflight(input int edges);
      in_valid = 1'b1; in_opcode = 6'h00; in_funct = 6'h20; in_a = 32'd3; in_b = 32'd4;
      out_ready = 1'b0;
      repeat (edges) begin @(posedge clock); #1; in_valid = 1'b0; end
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_result", out_result, 32'd0);
      @(posedge clock); #1;
      check("rst_no_pulse", 32'(out_valid), 32'd0);
   endtask

   logic [5:0] op_tab [0:10] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05};
   logic [5:0] fn_tab [0:10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A,
                                 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 4))
         0: return 32'h7FFFFFFF;
         1: return 32'h80000000;
         2: return 32'hFFFFFFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [5:0]  op, fn;
      logic [31:0] a, b;
      int          idx;

      repeat (2) @(posedge clock);
      #1;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_alu_ctl", 32'(alu_ctl), 32'd0);
      check("reset_result", out_result, 32'd0);
      check("reset_taken", 32'(out_taken), 32'd0);
      check("reset_illegal", 32'(out_illegal), 32'd0);
      check("reset_ovf", 32'(out_ovf), 32'd0);
      reset = 1'b0;
      check("reset_in_ready", 32'(in_ready), 32'd1);

      run_req(6'h00, 6'h20, 32'd5, 32'd7, 0, 1'b0);
      run_req(6'h04, 6'h00, 32'h1234, 32'h1234, 0, 1'b0);
      run_req(6'h05, 6'h00, 32'h1234, 32'h1234, 0, 1'b0);
      run_req(6'h3F, 6'h00, 32'd9, 32'd9, 0, 1'b0);
      run_req(6'h00, 6'h20, 32'h7FFFFFFF, 32'd1, 0, 1'b0);
      run_req(6'h00, 6'h22, 32'h80000000, 32'd1, 5, 1'b1);
      run_req(6'h23, 6'h00, 32'h7FFFFFFF, 32'd1, 0, 1'b0);
      reset_midflight(1);
      reset_midflight(2);

      for (int n = 0; n < 40; n++) begin
         idx = $urandom_range(0, 11);
         if (idx == 11) begin
            op = 6'h00; fn = 6'h30 | 6'($urandom_range(0, 15));
         end else begin
            op = op_tab[idx]; fn = fn_tab[idx];
         end
         a = pick_operand();
         b = ($urandom_range(0, 1) == 1) ? a : pick_operand();
         run_req(op, fn, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
